mult_datapath: RTL and testbench

Booth radix-2 product datapath for the `multu` unit; sits directly downstream of the multiply control sequencer and consumes its `add0`, `doSub` and `a_s` strobes each `mClk` cycle. It holds the multiplicand, a 33-bit accumulator and the multiplier/low-product register, and feeds the current product LSB back to the sequencer. On the sequencer's `mult_done` pulse it captures the 64-bit result into an output holding register, which a consumer drains with a valid/ack handshake.

---
 rtl/mult_datapath.sv | 80 ++++++++
 tb/tb_mult_datapath.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_datapath.sv
// Booth radix-2 product datapath: multiplicand, 33-bit accumulator and
// multiplier/low-product register, plus a valid/ack result holding register.
module mult_datapath #(
  parameter int WIDTH = 32
) (
  input  logic                 mClk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  input  logic                 add0,
  input  logic                 doSub,
  input  logic                 a_s,
  input  logic                 mult_done,
  input  logic                 result_ack,
  output logic                 prod_LSB,
  output logic [2*WIDTH-1:0]   product,
  output logic [2*WIDTH-1:0]   result,
  output logic                 result_valid
);

  logic [WIDTH-1:0]   mc_q, mc_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   low_q, low_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               result_valid_q, result_valid_d;
  logic [WIDTH:0]     mc_sext;

  // The extra accumulator bit keeps -2^(WIDTH-1) * -2^(WIDTH-1) from overflowing.
  assign mc_sext  = {mc_q[WIDTH-1], mc_q};
  assign product  = {acc_q[WIDTH-1:0], low_q};
  assign prod_LSB = low_q[0];

  always_comb begin
    mc_d  = mc_q;
    acc_d = acc_q;
    low_d = low_q;
    if (load) begin
      mc_d  = mcand;
      acc_d = '0;
      low_d = mplier;
    end else if (a_s) begin
      {acc_d, low_d} = {acc_q[WIDTH], acc_q, low_q[WIDTH-1:1]};
    end else if (!add0) begin
      acc_d = doSub ? (acc_q - mc_sext) : (acc_q + mc_sext);
    end
  end

  // Capture beats ack so a back-to-back result is never dropped.
  always_comb begin
    result_d       = result_q;
    result_valid_d = result_valid_q;
    if (mult_done) begin
      result_d       = product;
      result_valid_d = 1'b1;
    end else if (result_ack) begin
      result_valid_d = 1'b0;
    end
  end

  always_ff @(posedge mClk or posedge reset) begin
    if (reset) begin
      mc_q           <= '0;
      acc_q          <= '0;
      low_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      mc_q           <= mc_d;
      acc_q          <= acc_d;
      low_q          <= low_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath: directed Booth products, datapath
// step checks, result handshake, async reset and randomized operands.
module tb_mult_datapath;
  localparam int W = 32;

  logic           mClk = 1'b0;
  logic           reset, load, add0, doSub, a_s, mult_done, result_ack;
  logic [W-1:0]   mcand, mplier;
  logic           prod_LSB, result_valid;
  logic [2*W-1:0] product, result;

  int checks   = 0;
  int failures = 0;

  mult_datapath #(.WIDTH(W)) dut (
    .mClk(mClk), .reset(reset), .load(load), .mcand(mcand), .mplier(mplier),
    .add0(add0), .doSub(doSub), .a_s(a_s), .mult_done(mult_done),
    .result_ack(result_ack), .prod_LSB(prod_LSB), .product(product),
    .result(result), .result_valid(result_valid)
  );

  always #5 mClk = ~mClk;

  task automatic idle();
    load = 1'b0; a_s = 1'b0; add0 = 1'b1; doSub = 1'b0;
    mult_done = 1'b0; result_ack = 1'b0;
  endtask

  task automatic tick();
    @(posedge mClk); #1;
  endtask

  task automatic do_load(input logic [W-1:0] a, input logic [W-1:0] b);
    load = 1'b1; mcand = a; mplier = b;
    tick();
    load = 1'b0; mcand = $urandom; mplier = $urandom;
  endtask

  // Acts as the sequencer: Booth recoding from the multiplier bits themselves.
  task automatic booth(input logic [W-1:0] b, input int nsteps);
    logic prev;
    prev = 1'b0;
    for (int i = 0; i < nsteps; i++) begin
      checks++;
      if (prod_LSB !== b[i]) begin
        failures++;
        $display("FAIL prod_lsb step %0d: got %b want %b", i, prod_LSB, b[i]);
      end
      a_s = 1'b0; add0 = (b[i] == prev); doSub = b[i] & ~prev;
      tick();
      a_s = 1'b1; add0 = 1'b0; doSub = $urandom_range(0, 1);
      tick();
      a_s = 1'b0; add0 = 1'b1; doSub = 1'b0;
      prev = b[i];
    end
  endtask

  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] want, input string name);
    do_load(a, b);
    booth(b, W);
    checks++;
    if (product !== want) begin
      failures++;
      $display("FAIL %s product: got %h want %h", name, product, want);
    end
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    checks++;
    if (result !== want || result_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s result: got %h/%b want %h/1", name, result, result_valid, want);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] ea, eb;
    ea = $signed(a);
    eb = $signed(b);
    return ea * eb;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (product !== '0 || result !== '0 || result_valid !== 1'b0 || prod_LSB !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got %h %h %b %b want 0 0 0 0", product, result, result_valid, prod_LSB);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    run_mult(32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, "7x-3");
    run_mult(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "min_sq");
    run_mult(32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, "min_x1");
  endtask

  // -0x01010101 added 255 times leaves acc = -(2^32-1) = 0x1_00000001.
  task automatic test_add_shift();
    do_load(32'hFEFE_FEFF, 32'h0000_0002);
    a_s = 1'b0; add0 = 1'b1; doSub = 1'b1;
    tick();
    checks++;
    if (product !== 64'h0000_0000_0000_0002) begin
      failures++;
      $display("FAIL add0_hold: got %h want %h", product, 64'h2);
    end
    add0 = 1'b0; doSub = 1'b0;
    for (int i = 0; i < 255; i++) tick();
    add0 = 1'b1; doSub = 1'b1;
    tick();
    checks++;
    if (product !== 64'h0000_0001_0000_0002) begin
      failures++;
      $display("FAIL add_accum: got %h want %h", product, 64'h0000_0001_0000_0002);
    end
    a_s = 1'b1; add0 = 1'b0;
    tick();
    checks++;
    if (product !== 64'h8000_0000_8000_0001 || prod_LSB !== 1'b1) begin
      failures++;
      $display("FAIL shift1: got %h/%b want %h/1", product, prod_LSB, 64'h8000_0000_8000_0001);
    end
    tick();
    checks++;
    if (product !== 64'hC000_0000_4000_0000 || prod_LSB !== 1'b0) begin
      failures++;
      $display("FAIL shift2_sign: got %h/%b want %h/0", product, prod_LSB, 64'hC000_0000_4000_0000);
    end
    a_s = 1'b0; add0 = 1'b0; doSub = 1'b1;
    tick();
    checks++;
    if (product !== 64'hC101_0101_4000_0000) begin
      failures++;
      $display("FAIL sub_step: got %h want %h", product, 64'hC101_0101_4000_0000);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] want;
    run_mult(32'd11, 32'd13, 64'd143, "11x13");
    want = ref_mul(-32'sd9, 32'd4);
    do_load(-32'sd9, 32'd4);
    booth(32'd4, W);
    mult_done = 1'b1; result_ack = 1'b1;
    tick();
    mult_done = 1'b0; result_ack = 1'b0;
    checks++;
    if (result !== want || result_valid !== 1'b1) begin
      failures++;
      $display("FAIL done_and_ack: got %h/%b want %h/1", result, result_valid, want);
    end
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    checks++;
    if (result !== want || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL ack_alone: got %h/%b want %h/0", result, result_valid, want);
    end
    do_load(32'd5, 32'd6);
    checks++;
    if (result !== want || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL load_keeps_result: got %h/%b want %h/0", result, result_valid, want);
    end
  endtask

  task automatic test_reset_mid();
    run_mult(32'h1234_5678, 32'h9ABC_DEF1, ref_mul(32'h1234_5678, 32'h9ABC_DEF1), "pre_abort");
    do_load(32'hDEAD_BEEF, 32'hF0F0_F0F3);
    booth(32'hF0F0_F0F3, 17);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (product !== '0 || result !== '0 || result_valid !== 1'b0 || prod_LSB !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got %h %h %b %b want 0 0 0 0", product, result, result_valid, prod_LSB);
    end
    tick();
    reset = 1'b0;
    tick();
    run_mult(32'd3, 32'd5, 64'h0000_0000_0000_000F, "3x5_after_abort");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int n = 0; n < 20; n++) begin
      a = $urandom; b = $urandom;
      case (n % 5)
        0: a = 32'h8000_0000;
        1: b = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_mult(a, b, ref_mul(a, b), "random");
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
    end
  endtask

  initial begin
    idle();
    mcand = '0; mplier = '0;
    test_reset();
    test_directed();
    test_add_shift();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
